// File: rtl/mpu_alu_ctl.sv
// Command sequencer for mpu_alu: masks operands, holds them for the ALU,
// samples res/flags and returns them on a valid/ready response port.
module mpu_alu_ctl #(
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [1:0]       cmd_size,
   input  logic [63:0]      cmd_o0,
   input  logic [63:0]      cmd_o1,
   input  logic [63:0]      cmd_o2,
   output logic [3:0]       alu_op,
   output logic [1:0]       alu_size,
   output logic [63:0]      alu_o0,
   output logic [63:0]      alu_o1,
   output logic [63:0]      alu_o2,
   input  logic [63:0]      alu_res,
   input  logic [7:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_res,
   output logic [7:0]       rsp_flags,
   output logic [CNT_W-1:0] hit_cnt,
   input  logic             hit_clr,
   output logic             busy
);

   localparam int WCW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic [3:0]       op_q, op_d;
   logic [1:0]       size_q, size_d;
   logic [63:0]      o0_q, o0_d;
   logic [63:0]      o1_q, o1_d;
   logic [63:0]      o2_q, o2_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [63:0]      res_q, res_d;
   logic [7:0]       flags_q, flags_d;
   logic [CNT_W-1:0] hit_q, hit_d;

   function automatic logic [63:0] size_mask(input logic [1:0] s);
      logic [63:0] m;
      unique case (s)
         2'b00:   m = 64'h0000_0000_0000_00FF;
         2'b01:   m = 64'h0000_0000_0000_FFFF;
         2'b10:   m = 64'h0000_0000_FFFF_FFFF;
         default: m = '1;
      endcase
      return m;
   endfunction

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      op_d        = op_q;
      size_d      = size_q;
      o0_d        = o0_q;
      o1_d        = o1_q;
      o2_d        = o2_q;
      rsp_valid_d = rsp_valid_q;
      res_d       = res_q;
      flags_d     = flags_q;
      hit_d       = hit_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               size_d  = cmd_size;
               o0_d    = cmd_o0 & size_mask(cmd_size);
               o1_d    = cmd_o1 & size_mask(cmd_size);
               o2_d    = cmd_o2 & size_mask(cmd_size);
               wait_d  = WCW'(WAIT_CYCLES);
               state_d = HOLD;
            end
         end
         HOLD: begin
            wait_d = wait_q - WCW'(1);
            if (wait_q == WCW'(1)) begin
               res_d       = alu_res & size_mask(size_q);
               flags_d     = alu_flags;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
               if (alu_flags[0] && (hit_q != {CNT_W{1'b1}}))
                  hit_d = hit_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // clear wins over a same-cycle increment
      if (hit_clr)
         hit_d = '0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         op_q        <= '0;
         size_q      <= '0;
         o0_q        <= '0;
         o1_q        <= '0;
         o2_q        <= '0;
         rsp_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
         hit_q       <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         op_q        <= op_d;
         size_q      <= size_d;
         o0_q        <= o0_d;
         o1_q        <= o1_d;
         o2_q        <= o2_d;
         rsp_valid_q <= rsp_valid_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         hit_q       <= hit_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign alu_op    = op_q;
   assign alu_size  = size_q;
   assign alu_o0    = o0_q;
   assign alu_o1    = o1_q;
   assign alu_o2    = o2_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_res   = res_q;
   assign rsp_flags = flags_q;
   assign hit_cnt   = hit_q;

endmodule

// File: tb/tb_mpu_alu_ctl.sv
// Bench for mpu_alu_ctl: mock ALU, directed cases and randomized commands
// checked against an operand-level reference model.
module tb_mpu_alu_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;

   logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
   logic [3:0]  cmd_op = '0;
   logic [1:0]  cmd_size = '0;
   logic [63:0] cmd_o0 = '0, cmd_o1 = '0, cmd_o2 = '0;
   logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
   logic        hit_clr = 1'b0, hit_clr2 = 1'b0;

   logic        cmd_ready, rsp_valid, busy;
   logic [3:0]  alu_op;
   logic [1:0]  alu_size;
   logic [63:0] alu_o0, alu_o1, alu_o2, alu_res, rsp_res;
   logic [7:0]  alu_flags, rsp_flags;
   logic [15:0] hit_cnt;

   logic        cmd_ready2, rsp_valid2, busy2;
   logic [3:0]  alu_op2;
   logic [1:0]  alu_size2;
   logic [63:0] alu_o02, alu_o12, alu_o22, alu_res2, rsp_res2;
   logic [7:0]  alu_flags2, rsp_flags2;
   logic [1:0]  hit_cnt2;

   logic [63:0] exp_res, exp_o0;
   logic [7:0]  exp_flags;
   int          exp_hit = 0;

   always #5 clk = ~clk;

   function automatic logic mock_f(logic [3:0] op, logic [63:0] a, logic [63:0] b, logic [63:0] c);
      case (op)
         4'd1:    return (a & c) != 64'd0;
         4'd2:    return (a & c) == (b & c);
         4'd3:    return a < b;
         default: return ^(a ^ b);
      endcase
   endfunction

   always_comb begin
      alu_res   = ~(alu_o0 ^ alu_o1 ^ alu_o2);
      alu_flags = {alu_op, 3'b000, mock_f(alu_op, alu_o0, alu_o1, alu_o2)};
      alu_res2  = ~(alu_o02 ^ alu_o12 ^ alu_o22);
      alu_flags2 = {alu_op2, 3'b000, mock_f(alu_op2, alu_o02, alu_o12, alu_o22)};
   end

   mpu_alu_ctl u_dut (
      .sys_clk(clk), .sys_rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_size(cmd_size),
      .cmd_o0(cmd_o0), .cmd_o1(cmd_o1), .cmd_o2(cmd_o2),
      .alu_op(alu_op), .alu_size(alu_size),
      .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
      .alu_res(alu_res), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags),
      .hit_cnt(hit_cnt), .hit_clr(hit_clr), .busy(busy)
   );

   mpu_alu_ctl #(.WAIT_CYCLES(3), .CNT_W(2)) u_small (
      .sys_clk(clk), .sys_rst(rst),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_op(cmd_op), .cmd_size(cmd_size),
      .cmd_o0(cmd_o0), .cmd_o1(cmd_o1), .cmd_o2(cmd_o2),
      .alu_op(alu_op2), .alu_size(alu_size2),
      .alu_o0(alu_o02), .alu_o1(alu_o12), .alu_o2(alu_o22),
      .alu_res(alu_res2), .alu_flags(alu_flags2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
      .rsp_res(rsp_res2), .rsp_flags(rsp_flags2),
      .hit_cnt(hit_cnt2), .hit_clr(hit_clr2), .busy(busy2)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] msk(logic [1:0] s);
      if (s == 2'd0) return 64'hFF;
      if (s == 2'd1) return 64'hFFFF;
      if (s == 2'd2) return 64'hFFFF_FFFF;
      return ~64'd0;
   endfunction

   task automatic set_cmd(logic [3:0] op, logic [1:0] sz, logic [63:0] a, logic [63:0] b, logic [63:0] c);
      logic [63:0] m0, m1, m2;
      cmd_op = op; cmd_size = sz; cmd_o0 = a; cmd_o1 = b; cmd_o2 = c;
      m0 = a & msk(sz); m1 = b & msk(sz); m2 = c & msk(sz);
      exp_o0    = m0;
      exp_res   = ~(m0 ^ m1 ^ m2) & msk(sz);
      exp_flags = {op, 3'b000, mock_f(op, m0, m1, m2)};
   endtask

   // returns one time unit after the accepting edge of the main DUT
   task automatic issue(logic [3:0] op, logic [1:0] sz, logic [63:0] a, logic [63:0] b, logic [63:0] c);
      int n;
      @(negedge clk);
      set_cmd(op, sz, a, b, c);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (exp_flags[0]) exp_hit++;
   endtask

   task automatic wait_rsp(string tag);
      int k;
      k = 0;
      while (!rsp_valid && k < 40) begin
         @(posedge clk);
         #1 k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'd1);
      chk({tag, "_res"}, rsp_res, exp_res);
      chk({tag, "_flags"}, 64'(rsp_flags), 64'(exp_flags));
      chk({tag, "_alu_o0"}, alu_o0, exp_o0);
      chk({tag, "_hit"}, 64'(hit_cnt), 64'(exp_hit));
   endtask

   task automatic pop(string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 chk({tag, "_pop"}, 64'(rsp_valid), 64'd0);
      rsp_ready = 1'b0;
   endtask

   task automatic small_cmd(logic do_clr, output int lat);
      int n;
      @(negedge clk);
      set_cmd(4'd1, 2'd0, 64'h1, 64'h0, 64'h1);
      cmd_valid2 = 1'b1;
      n = 0;
      while (!cmd_ready2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 cmd_valid2 = 1'b0;
      lat = 0;
      while (!rsp_valid2 && lat < 40) begin
         if (do_clr && lat == 2) begin
            @(negedge clk);
            hit_clr2 = 1'b1;
         end
         @(posedge clk);
         #1 lat++;
         hit_clr2 = 1'b0;
      end
      @(negedge clk);
      rsp_ready2 = 1'b1;
      @(posedge clk);
      #1 rsp_ready2 = 1'b0;
   endtask

   initial begin
      logic [63:0] held;
      int          lat;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_hit", 64'(hit_cnt), 64'd0);
      chk("rst_alu_o0", alu_o0, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(4'd1, 2'd0, 64'h55, 64'hAA, 64'h55);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_rsp("t1");
      chk("t1_f0", 64'(rsp_flags[0]), 64'd1);
      chk("t1_hit1", 64'(hit_cnt), 64'd1);
      pop("t1");

      issue(4'd2, 2'd0, 64'h55, 64'h54, 64'hFF);
      wait_rsp("t2a");
      chk("t2a_f0", 64'(rsp_flags[0]), 64'd0);
      pop("t2a");
      issue(4'd2, 2'd0, 64'h55, 64'h54, 64'hFE);
      wait_rsp("t2b");
      chk("t2b_f0", 64'(rsp_flags[0]), 64'd1);
      pop("t2b");

      issue(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_FF54, 64'h55, 64'h0);
      chk("t3_alu_o0", alu_o0, 64'h54);
      wait_rsp("t3");
      chk("t3_f0", 64'(rsp_flags[0]), 64'd1);
      pop("t3");

      issue(4'd7, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_1111_2222, 64'h0F0F_0F0F_0F0F_0F0F);
      wait_rsp("t4");
      held = rsp_res;
      @(negedge clk);
      cmd_op = 4'd9; cmd_size = 2'd3; cmd_o0 = 64'hDEAD_BEEF_0000_0001;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("t4_hold_res", rsp_res, held);
         chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
         chk("t4_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("t4_alu_o0", alu_o0, exp_o0);
      end
      cmd_valid = 1'b0;
      pop("t4");
      chk("t4_idle_ready", 64'(cmd_ready), 64'd1);
      issue(4'd9, 2'd3, 64'hDEAD_BEEF_0000_0001, 64'h5, 64'h6);
      chk("t4_new_o0", alu_o0, 64'hDEAD_BEEF_0000_0001);
      wait_rsp("t4n");
      pop("t4n");

      for (int i = 0; i < 30; i++) begin
         issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         wait_rsp("rnd");
         held = rsp_res;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1 chk("rnd_stall", rsp_res, held);
         end
         pop("rnd");
      end

      for (int i = 0; i < 5; i++) begin
         small_cmd(1'b0, lat);
         if (i == 0) chk("t5_lat", 64'(lat), 64'd3);
      end
      chk("t5_sat", 64'(hit_cnt2), 64'd3);
      small_cmd(1'b1, lat);
      chk("t5_clr_lat", 64'(lat), 64'd3);
      chk("t5_clr", 64'(hit_cnt2), 64'd0);
      small_cmd(1'b0, lat);
      chk("t5_after_clr", 64'(hit_cnt2), 64'd1);

      issue(4'd1, 2'd0, 64'h1, 64'h0, 64'h1);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      exp_hit = 0;
      chk("t6_ready", 64'(cmd_ready), 64'd1);
      chk("t6_hit", 64'(hit_cnt), 64'd0);
      chk("t6_alu_o0", alu_o0, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
      end
      chk("t6_hit_end", 64'(hit_cnt), 64'd0);
      chk("t6_small_hit", 64'(hit_cnt2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
